// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core.
// Sequences the shared ALU, the unified memory port, the register file and the
// PC through fetch/decode/execute/memory/writeback. Stalls on MemReady.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   op, funct3         opcode and funct3 from the instruction register
//   Zero, Negative,    ALU flags used to resolve branches
//   CarryOut, Overflow (CarryOut = 1 means no borrow on subtract)
//   MemReady           memory completes the current access this cycle
//   PCWrite .. ALUOp   datapath controls, combinational from State
//   Illegal            sticky flag, set when an unsupported opcode traps
//   State              current state, for debug
module multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       Negative,
  input  logic       CarryOut,
  input  logic       Overflow,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_LUI      = 4'd13,
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  state_t state;
  logic   illegal_q;
  logic   taken;

  // Opcode dispatch out of DECODE; anything unsupported traps.
  function automatic state_t decode_next(input logic [6:0] opc);
    case (opc)
      OP_LOAD, OP_STORE: decode_next = S_MEMADR;
      OP_RTYPE:          decode_next = S_EXECR;
      OP_ITYPE:          decode_next = S_EXECI;
      OP_JAL:            decode_next = S_JAL;
      OP_JALR:           decode_next = S_JALR;
      OP_BRANCH:         decode_next = S_BRANCH;
      OP_LUI:            decode_next = S_LUI;
      default:           decode_next = S_TRAP;
    endcase
  endfunction

  // State register and sticky Illegal flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= state_t'(RESET_STATE);
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:    if (MemReady) state <= S_DECODE;
        S_DECODE: begin
          state <= decode_next(op);
          if (decode_next(op) == S_TRAP) illegal_q <= 1'b1;
        end
        S_MEMADR:   state <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (MemReady) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (MemReady) state <= S_FETCH;
        S_EXECR:    state <= S_ALUWB;
        S_EXECI:    state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_JAL:      state <= S_ALUWB;
        S_JALR:     state <= S_LINK;
        S_LINK:     state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_LUI:      state <= S_FETCH;
        S_TRAP:     state <= S_TRAP;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Branch resolution from the compare (rs1 - rs2) flags.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = Zero;
      3'b001:  taken = ~Zero;
      3'b100:  taken = Negative ^ Overflow;
      3'b101:  taken = ~(Negative ^ Overflow);
      3'b110:  taken = ~CarryOut;
      3'b111:  taken = CarryOut;
      default: taken = 1'b0;
    endcase
  end

  // Control decode from the current state; enables are suppressed during reset.
  always_comb begin
    PCWrite   = 1'b0;
    AdrSrc    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (state)
      S_FETCH: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: RegWrite = 1'b1;
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
      S_JALR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = 1'b1;
      end
      // rs1 was consumed in JALR, so rd == rs1 is safe here.
      S_LINK: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        RegWrite  = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        PCWrite = taken;
      end
      S_LUI: begin
        ALUSrcA   = 2'b11;
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        RegWrite  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign Illegal = illegal_q;
  assign State   = 4'(state);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus side walks each
// instruction through its expected state path and queues the expected
// controls per cycle; the monitor pops one entry per cycle and compares.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero, Negative, CarryOut, Overflow;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic       Illegal;
  logic [3:0] State;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3),
    .Zero(Zero), .Negative(Negative), .CarryOut(CarryOut), .Overflow(Overflow),
    .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .Illegal(Illegal), .State(State)
  );

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
    logic       illegal;
  } exp_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4,
                 K_JALR = 5, K_BR = 6, K_LUI = 7, K_ILL = 8;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  // Expected controls for one cycle, straight from the per-state table.
  function automatic exp_t model(input logic [3:0] st, input logic mr,
                                 input logic rst, input logic tk);
    exp_t e;
    e = '0;
    e.state = st;
    case (st)
      4'd0:  begin e.mem_read = 1; e.alu_src_b = 2'b10; e.result_src = 2'b10;
                   e.ir_write = mr; e.pc_write = mr; end
      4'd1:  begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b01; end
      4'd2:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; end
      4'd3:  begin e.adr_src = 1; e.mem_read = 1; end
      4'd4:  begin e.result_src = 2'b01; e.reg_write = 1; end
      4'd5:  begin e.adr_src = 1; e.mem_write = 1; end
      4'd6:  begin e.alu_src_a = 2'b10; e.alu_op = 2'b10; end
      4'd7:  e.reg_write = 1;
      4'd8:  begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.alu_op = 2'b10; end
      4'd9:  begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.pc_write = 1; end
      4'd10: begin e.alu_src_a = 2'b10; e.alu_op = 2'b01; e.pc_write = tk; end
      4'd11: begin e.alu_src_a = 2'b10; e.alu_src_b = 2'b01; e.result_src = 2'b10;
                   e.pc_write = 1; end
      4'd12: begin e.alu_src_a = 2'b01; e.alu_src_b = 2'b10; e.result_src = 2'b10;
                   e.reg_write = 1; end
      4'd13: begin e.alu_src_a = 2'b11; e.alu_src_b = 2'b01; e.result_src = 2'b10;
                   e.reg_write = 1; end
      4'd15: e.illegal = 1;
      default: ;
    endcase
    if (rst) begin
      e.pc_write = 0; e.ir_write = 0; e.reg_write = 0; e.mem_read = 0; e.mem_write = 0;
    end
    return e;
  endfunction

  // Monitor: one DUT presentation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t got, e;
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {State, PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
             ResultSrc, ALUSrcA, ALUSrcB, ALUOp, Illegal};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL ctrl cycle=%0d got=%h (state %0d) required=%h (state %0d)",
                 cyc, got, got.state, e, e.state);
      end
    end
  end

  // One clock of stimulus with its expected response queued.
  task automatic step(input logic [3:0] st, input logic mr, input logic rst,
                      input logic [3:0] fl, input logic tk);
    MemReady = mr;
    reset    = rst;
    {Zero, Negative, CarryOut, Overflow} = fl;
    exp_q.push_back(model(st, mr, rst, tk));
    @(posedge clk);
    #1;
  endtask

  task automatic stepr(input logic [3:0] st, input logic mr);
    step(st, mr, 1'b0, 4'($urandom), 1'b0);
  endtask

  // Memory wait: w cycles of MemReady low, then either completion or a reset
  // that abandons the access while MemReady is high.
  task automatic mem_wait(input logic [3:0] st, input int w, input bit abort);
    for (int i = 0; i < w; i++) stepr(st, 1'b0);
    if (abort) step(st, 1'b1, 1'b1, 4'($urandom), 1'b0);
    else       stepr(st, 1'b1);
  endtask

  // Drive one instruction from FETCH back to FETCH (or into TRAP and reset).
  task automatic run_instr(input int kind, input logic [6:0] opc, input logic [2:0] f3,
                           input int fw, input int mw, input bit abort,
                           input logic [3:0] fl, input logic tk, input int trap_cycles);
    op = opc;
    funct3 = f3;
    mem_wait(4'd0, fw, 1'b0);
    stepr(4'd1, 1'($urandom));
    case (kind)
      K_LW:   begin stepr(4'd2, 1'($urandom)); mem_wait(4'd3, mw, abort);
                    if (!abort) stepr(4'd4, 1'($urandom)); end
      K_SW:   begin stepr(4'd2, 1'($urandom)); mem_wait(4'd5, mw, abort); end
      K_R:    begin stepr(4'd6, 1'($urandom)); stepr(4'd7, 1'($urandom)); end
      K_I:    begin stepr(4'd8, 1'($urandom)); stepr(4'd7, 1'($urandom)); end
      K_JAL:  begin stepr(4'd9, 1'($urandom)); stepr(4'd7, 1'($urandom)); end
      K_JALR: begin stepr(4'd11, 1'($urandom)); stepr(4'd12, 1'($urandom)); end
      K_BR:   step(4'd10, 1'($urandom), 1'b0, fl, tk);
      K_LUI:  stepr(4'd13, 1'($urandom));
      default: begin
        for (int i = 0; i < trap_cycles; i++) stepr(4'd15, 1'($urandom));
        step(4'd15, 1'($urandom), 1'b1, 4'($urandom), 1'b0);
      end
    endcase
  endtask

  function automatic logic [6:0] kind_op(input int k);
    case (k)
      K_LW:   return 7'b0000011;
      K_SW:   return 7'b0100011;
      K_R:    return 7'b0110011;
      K_I:    return 7'b0010011;
      K_JAL:  return 7'b1101111;
      K_JALR: return 7'b1100111;
      K_BR:   return 7'b1100011;
      default: return 7'b0110111;
    endcase
  endfunction

  // Random rs1/rs2 compare: flags from the subtraction, outcome from the
  // architectural comparison itself.
  task automatic rand_branch(input logic [2:0] f3, output logic [3:0] fl, output logic tk);
    logic [31:0] a, b, d;
    a = $urandom;
    case ($urandom_range(0, 3))
      0:       b = a;
      1:       b = a ^ 32'h8000_0000;
      default: b = $urandom;
    endcase
    d  = a - b;
    fl = {(a == b), d[31], (a >= b), ((a[31] ^ b[31]) & (d[31] ^ a[31]))};
    case (f3)
      3'b000:  tk = (a == b);
      3'b001:  tk = (a != b);
      3'b100:  tk = ($signed(a) < $signed(b));
      3'b101:  tk = ($signed(a) >= $signed(b));
      3'b110:  tk = (a < b);
      3'b111:  tk = (a >= b);
      default: tk = 1'b0;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [3:0] fl;
    logic       tk;
    logic [6:0] rop;
    int         k;
    reset = 1'b1; MemReady = 1'b1; op = 7'b0000011; funct3 = 3'b010;
    {Zero, Negative, CarryOut, Overflow} = 4'b0;
    @(posedge clk); #1;

    // Reset held two cycles with MemReady high, then lw with a 3-cycle stall.
    step(4'd0, 1'b1, 1'b1, 4'h0, 1'b0);
    step(4'd0, 1'b1, 1'b1, 4'h0, 1'b0);
    run_instr(K_LW, 7'b0000011, 3'b010, 0, 3, 0, 4'h0, 1'b0, 0);
    // sw, no stall.
    run_instr(K_SW, 7'b0100011, 3'b010, 0, 0, 0, 4'h0, 1'b0, 0);
    // Branch sweep; flags are {Zero, Negative, CarryOut, Overflow}.
    run_instr(K_BR, 7'b1100011, 3'b000, 0, 0, 0, 4'b1000, 1'b1, 0);
    run_instr(K_BR, 7'b1100011, 3'b001, 0, 0, 0, 4'b1000, 1'b0, 0);
    run_instr(K_BR, 7'b1100011, 3'b100, 0, 0, 0, 4'b0100, 1'b1, 0);
    run_instr(K_BR, 7'b1100011, 3'b111, 0, 0, 0, 4'b0000, 1'b0, 0);
    run_instr(K_BR, 7'b1100011, 3'b010, 0, 0, 0, 4'b1111, 1'b0, 0);
    run_instr(K_BR, 7'b1100011, 3'b110, 0, 0, 0, 4'b0000, 1'b1, 0);
    // jalr, then fence-like opcode traps for 10 cycles and reset recovers.
    run_instr(K_JALR, 7'b1100111, 3'b000, 0, 0, 0, 4'h0, 1'b0, 0);
    run_instr(K_ILL, 7'b0001111, 3'b000, 0, 0, 0, 4'h0, 1'b0, 10);
    // Reset during a stalled store abandons it.
    run_instr(K_SW, 7'b0100011, 3'b010, 1, 2, 1, 4'h0, 1'b0, 0);
    run_instr(K_LUI, 7'b0110111, 3'b000, 2, 0, 0, 4'h0, 1'b0, 0);

    // Randomized instruction stream.
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 17);
      if (k > K_ILL) k = k - 9;
      if (k == K_ILL) begin
        do rop = 7'($urandom);
        while (rop inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                           7'b1101111, 7'b1100111, 7'b1100011, 7'b0110111});
        run_instr(K_ILL, rop, 3'($urandom), $urandom_range(0, 2), 0, 0,
                  4'h0, 1'b0, $urandom_range(0, 4));
      end else begin
        funct3 = 3'($urandom);
        rand_branch(funct3, fl, tk);
        run_instr(k, kind_op(k), funct3, $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 15) == 0), fl, tk, 0);
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multicycle RV32I core. It sequences the shared ALU, unified instruction/data memory port, register file and PC register through fetch/decode/execute/memory/writeback states. It resolves branch conditions from funct3 and the ALU flags. It stalls on a memory ready handshake.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH); kept as a parameter for the bench only, never overridden in the core.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
op  in  7  instruction opcode, from the IR
funct3  in  3  instruction funct3, from the IR
Zero  in  1  ALU flag
Negative  in  1  ALU flag
CarryOut  in  1  ALU flag; 1 = no borrow on subtract
Overflow  in  1  ALU flag
MemReady  in  1  memory completes the current access this cycle
PCWrite  out  1  load PC from Result
AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load IR and OldPC
RegWrite  out  1  register file write enable
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
ALUSrcB  out  2  00 = rs2, 01 = imm, 10 = constant 4
ALUOp  out  2  00 = add, 01 = subtract/compare, 10 = decode by funct
Illegal  out  1  sticky, unsupported opcode trapped
State  out  4  current state, for debug

Behaviour:
- Outputs are combinational from State. MemReady gates PCWrite and IRWrite in FETCH. Any output not listed for a state is 0.
- reset high at a clock edge: State <- FETCH and Illegal <- 0.
- While reset is high, PCWrite, IRWrite, RegWrite, MemRead and MemWrite are forced to 0.
- Reset asserted mid-wait (in FETCH, MEMREAD or MEMWRITE): the access is abandoned and the pending MemReady is ignored.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BRANCH=10, JALR=11, LINK=12, LUI=13, TRAP=15.
- FETCH
  - Outputs: MemRead=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCWrite=MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE
  - Outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch/JAL target into ALUOut).
  - Next state by op: 0000011 and 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1101111 -> JAL; 1100111 -> JALR; 1100011 -> BRANCH; 0110111 -> LUI; any other -> TRAP.
- MEMADR
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
  - Next: MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD
  - Outputs: AdrSrc=1, MemRead=1, ResultSrc=00.
  - Waits for MemReady=1, then MEMWB.
- MEMWB
  - Outputs: ResultSrc=01, RegWrite=1.
  - Next: FETCH.
- MEMWRITE
  - Outputs: AdrSrc=1, MemWrite=1, ResultSrc=00.
  - MemWrite stays held until MemReady=1, then FETCH.
- EXECR
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
  - Next: ALUWB.
- EXECI
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
  - Next: ALUWB.
- ALUWB
  - Outputs: ResultSrc=00, RegWrite=1.
  - Next: FETCH.
- JAL
  - Outputs: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1.
  - Next: ALUWB (rd <- OldPC+4).
- JALR
  - Outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCWrite=1.
  - Next: LINK.
- LINK
  - Outputs: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=10, RegWrite=1.
  - Next: FETCH.
  - rd==rs1 is safe: rs1 is consumed in JALR before it is written here.
- BRANCH
  - Outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=taken.
  - Next: FETCH.
  - taken by funct3:
    - 000: Zero
    - 001: !Zero
    - 100: Negative^Overflow
    - 101: !(Negative^Overflow)
    - 110: !CarryOut
    - 111: CarryOut
    - 010, 011: 0 (no trap)
- LUI
  - Outputs: ALUSrcA=11, ALUSrcB=01, ALUOp=00, ResultSrc=10, RegWrite=1.
  - Next: FETCH.
- TRAP
  - Illegal=1, all enables 0.
  - Stays in TRAP until reset.
- Latency with MemReady tied high:
  - lw: 5 cycles
  - sw, R-type, I-type, JAL, JALR: 4 cycles
  - branch, LUI: 3 cycles

Test Plan:
- Reset then hold reset 2 cycles with MemReady=1 -> State=0, no PCWrite/IRWrite/MemRead. After release, FETCH asserts MemRead=1 and IRWrite=PCWrite=1.
- lw (op=0000011), MemReady low for 3 cycles in MEMREAD -> State sequence 0,1,2,3,3,3,3,4,0. RegWrite=1 only in state 4 with ResultSrc=01.
- sw with MemReady=1 -> states 0,1,2,5,0. MemWrite=1 with AdrSrc=1 for exactly one cycle. RegWrite never asserted.
- Branch funct3 sweep from state 10:
  - beq with Zero=1 -> PCWrite=1
  - bne with Zero=1 -> PCWrite=0
  - blt with N=1, V=0 -> PCWrite=1
  - bgeu with C=0 -> PCWrite=0
  - funct3=010 -> PCWrite=0
- jalr (op=1100111) -> states 0,1,11,12,0. PCWrite in state 11 with ResultSrc=10; RegWrite in state 12 with ALUSrcA=01, ALUSrcB=10.
- op=0001111 -> TRAP, Illegal=1, held 10 cycles with all enables 0. Reset -> FETCH, Illegal=0.
